// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled serial receiver with 3-sample majority voting, optional parity,
// and a first-word-fall-through output FIFO with valid/ready handshake.
module uart_rx #(
    parameter int CLK_HZ     = 108000000,
    parameter int BAUD       = 115200,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    output logic       busy
);
    localparam int DIV = (CLK_HZ + BAUD * 8) / (BAUD * 16);
    localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {HUNT, IDLE, START, DATA, PAR, STOP} state_t;

    state_t          r_state, w_next;
    logic [DW-1:0]   r_div;
    logic [1:0]      r_sync;
    logic            r_prev, r_s7, r_s8, r_par;
    logic [3:0]      r_cnt;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic [AW:0]     r_wp, r_rp;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic            w_tick, w_rx, w_vote, w_mid, w_end, w_clr, w_par_ok;
    logic            w_push, w_ferr, w_perr, w_full, w_pop, w_wr;

    assign w_tick   = r_div == DW'(DIV - 1);
    assign w_rx     = r_sync[1];
    assign w_vote   = (r_s7 & r_s8) | (r_s7 & w_rx) | (r_s8 & w_rx);
    assign w_mid    = w_tick && r_cnt == 4'd9;
    assign w_end    = w_tick && r_cnt == 4'd15;
    assign w_par_ok = PARITY == 0 ? 1'b1 : ((^r_shift) ^ r_par) == (PARITY == 2);
    // HUNT counts only uninterrupted high ticks; IDLE holds the counter at 0 for the next start edge
    assign w_clr    = r_state == IDLE || w_ferr || (r_state == HUNT && !w_rx);
    assign w_full   = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign valid    = r_wp != r_rp;
    assign w_pop    = valid && ready;
    assign w_wr     = w_push && (!w_full || w_pop);
    assign data     = valid ? r_mem[r_rp[AW-1:0]] : 8'h00;
    assign busy     = r_state != HUNT && r_state != IDLE;

    always_comb begin
        w_next = r_state;
        w_push = 1'b0;
        w_ferr = 1'b0;
        w_perr = 1'b0;
        case (r_state)
            HUNT:  if (w_end && w_rx) w_next = IDLE;
            IDLE:  if (r_prev && !w_rx) w_next = START;
            START: if (w_mid && w_vote) w_next = IDLE; else if (w_end) w_next = DATA;
            DATA:  if (w_end && r_bit == 3'd7) w_next = PARITY != 0 ? PAR : STOP;
            PAR:   if (w_end) w_next = STOP;
            STOP: if (w_mid) begin
                w_next = w_vote ? IDLE : HUNT;
                w_ferr = !w_vote;
                w_perr = w_vote && !w_par_ok;
                w_push = w_vote && w_par_ok;
            end
            default: w_next = HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= HUNT;
            r_div      <= '0;
            r_sync     <= 2'b11;
            r_prev     <= 1'b1;
            r_s7       <= 1'b1;
            r_s8       <= 1'b1;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_wp       <= '0;
            r_rp       <= '0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_div      <= w_tick ? '0 : r_div + DW'(1);
            r_sync     <= {r_sync[0], rxd};
            r_prev     <= w_rx;
            r_cnt      <= w_clr ? 4'd0 : w_tick ? r_cnt + 4'd1 : r_cnt;
            r_bit      <= r_state != DATA ? 3'd0 : w_end ? r_bit + 3'd1 : r_bit;
            if (w_tick && r_cnt == 4'd7) r_s7 <= w_rx;
            if (w_tick && r_cnt == 4'd8) r_s8 <= w_rx;
            if (r_state == DATA && w_mid) r_shift <= {w_vote, r_shift[7:1]};
            if (r_state == PAR && w_mid) r_par <= w_vote;
            r_wp       <= r_wp + (AW + 1)'(w_wr);
            r_rp       <= r_rp + (AW + 1)'(w_pop);
            frame_err  <= w_ferr;
            parity_err <= w_perr;
            overrun    <= w_push && w_full && !w_pop;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_wr) r_mem[r_wp[AW-1:0]] <= r_shift;
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into two receivers (no parity / even parity); a negedge
// monitor checks every presented byte against a queue of expected bytes.
module tb_uart_rx;
    // DIV = 8 -> 128 clk per bit keeps the run short while exercising identical logic
    localparam int CLK_HZ = 108000000;
    localparam int BAUD   = 843750;
    localparam int BT     = 128;

    logic       clk = 1'b0, rst = 1'b1;
    logic       rxd0 = 1'b1, rxd1 = 1'b1, ready0 = 1'b1, ready1 = 1'b1;
    logic [7:0] data0, data1;
    logic       valid0, valid1, fe0_w, fe1_w, pe0_w, pe1_w, ov0_w, ov1_w, busy0, busy1;

    int         ntest = 0, nfail = 0, cyc = 0, stop_start = 0, busy_run = 0, busy_max = 0;
    int         fe0 = 0, pe0 = 0, ov0 = 0, fe1 = 0, pe1 = 0, ov1 = 0;
    bit         lat_chk = 1'b0;
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] tol [3] = '{8'h00, 8'hFF, 8'h81};
    int         bts [2] = '{BT - 2, BT + 2};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .PARITY(0), .FIFO_DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .rxd(rxd0), .data(data0), .valid(valid0), .ready(ready0),
        .frame_err(fe0_w), .parity_err(pe0_w), .overrun(ov0_w), .busy(busy0)
    );

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .PARITY(1), .FIFO_DEPTH(4)) u_par (
        .clk(clk), .rst(rst), .rxd(rxd1), .data(data1), .valid(valid1), .ready(ready1),
        .frame_err(fe1_w), .parity_err(pe1_w), .overrun(ov1_w), .busy(busy1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntest++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int d, input logic v, input int n);
        #1;
        if (d == 0) rxd0 = v; else rxd1 = v;
        repeat (n) @(posedge clk);
    endtask

    // par < 0 means no parity bit on the line
    task automatic send(input int d, input logic [7:0] b, input int bt, input int par, input logic stop);
        drive(d, 1'b0, bt);
        for (int i = 0; i < 8; i++) drive(d, b[i], bt);
        if (par >= 0) drive(d, par[0], bt);
        #1 stop_start = cyc;
        drive(d, stop, bt);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            fe0 += int'(fe0_w); pe0 += int'(pe0_w); ov0 += int'(ov0_w);
            fe1 += int'(fe1_w); pe1 += int'(pe1_w); ov1 += int'(ov1_w);
            busy_run = busy0 ? busy_run + 1 : 0;
            if (busy_run > busy_max) busy_max = busy_run;
            if (valid0) begin
                ntest++;
                if (q0.size() == 0) begin
                    nfail++;
                    $display("FAIL rx0_unexpected: got %h expected no byte", data0);
                end else if (data0 !== q0[0]) begin
                    nfail++;
                    $display("FAIL rx0_data: got %h expected %h", data0, q0[0]);
                end
                if (ready0 && lat_chk) begin
                    ntest++;
                    if (cyc - stop_start < BT / 2 || cyc - stop_start > 3 * BT / 4) begin
                        nfail++;
                        $display("FAIL rx0_latency: got %0d clk after stop start expected %0d..%0d", cyc - stop_start, BT / 2, 3 * BT / 4);
                    end
                end
                if (ready0 && q0.size() > 0) void'(q0.pop_front());
            end
            if (valid1) begin
                ntest++;
                if (q1.size() == 0) begin
                    nfail++;
                    $display("FAIL rx1_unexpected: got %h expected no byte", data1);
                end else begin
                    if (data1 !== q1[0]) begin
                        nfail++;
                        $display("FAIL rx1_data: got %h expected %h", data1, q1[0]);
                    end
                    void'(q1.pop_front());
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", valid0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_data", data0, 0);
        chk("rst_frame_err", fe0_w, 0);
        chk("rst_parity_err", pe0_w, 0);
        chk("rst_overrun", ov0_w, 0);
        rst = 1'b0;
        drive(0, 1'b1, 20 * BT);
        // basic receive with latency check
        lat_chk = 1'b1;
        q0.push_back(8'h55);
        send(0, 8'h55, BT, -1, 1'b1);
        chk("basic_busy_gap", busy0, 0);
        q0.push_back(8'hA3);
        send(0, 8'hA3, BT, -1, 1'b1);
        lat_chk = 1'b0;
        drive(0, 1'b1, 2 * BT);
        chk("basic_all_rx", q0.size(), 0);
        chk("basic_no_ferr", fe0, 0);
        chk("basic_no_ovr", ov0, 0);
        // 3-clk glitch must not become a frame
        busy_max = 0;
        drive(0, 1'b0, 3);
        drive(0, 1'b1, 3 * BT);
        chk("glitch_busy_seen", busy_max > 0, 1);
        chk("glitch_busy_short", busy_max < 12 * BT / 16, 1);
        chk("glitch_busy_end", busy0, 0);
        chk("glitch_no_ferr", fe0, 0);
        // bit-time tolerance
        foreach (bts[j]) begin
            foreach (tol[k]) begin
                q0.push_back(tol[k]);
                send(0, tol[k], bts[j], -1, 1'b1);
            end
            drive(0, 1'b1, 2 * BT);
            chk("tol_all_rx", q0.size(), 0);
        end
        // framing error, line held low, then recovery through HUNT
        send(0, 8'h3C, BT, -1, 1'b0);
        drive(0, 1'b0, 2 * BT);
        drive(0, 1'b1, 3 * BT);
        chk("frame_err_cnt", fe0, 1);
        chk("frame_busy_low", busy0, 0);
        q0.push_back(8'h7E);
        send(0, 8'h7E, BT, -1, 1'b1);
        drive(0, 1'b1, 2 * BT);
        chk("frame_recover_rx", q0.size(), 0);
        chk("frame_err_once", fe0, 1);
        // even parity on the second receiver
        q1.push_back(8'h07);
        send(1, 8'h07, BT, 1, 1'b1);
        send(1, 8'h07, BT, 0, 1'b1);
        drive(1, 1'b1, 2 * BT);
        chk("par_good_rx", q1.size(), 0);
        chk("par_err_cnt", pe1, 1);
        chk("par_no_ferr", fe1, 0);
        chk("par_no_ovr", ov1, 0);
        // overrun with the consumer stalled
        #1 ready0 = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) q0.push_back(8'(i));
            send(0, 8'(i), BT, -1, 1'b1);
        end
        drive(0, 1'b1, BT);
        chk("ovr_cnt", ov0, 1);
        chk("ovr_valid_held", valid0, 1);
        chk("ovr_head", data0, 8'h01);
        #1 ready0 = 1'b1;
        repeat (10) @(posedge clk);
        chk("ovr_drained", q0.size(), 0);
        chk("ovr_empty", valid0, 0);
        // reset in the middle of a frame empties the FIFO
        #1 ready0 = 1'b0;
        q0.push_back(8'h11);
        send(0, 8'h11, BT, -1, 1'b1);
        drive(0, 1'b1, BT);
        chk("pre_rst_valid", valid0, 1);
        chk("pre_rst_data", data0, 8'h11);
        drive(0, 1'b0, BT);
        for (int i = 0; i < 3; i++) drive(0, i == 0 ? 1'b0 : 1'b1, BT);
        #1 rst = 1'b1;
        rxd0 = 1'b1;
        q0.delete();
        @(posedge clk);
        #1;
        chk("rst_mid_valid", valid0, 0);
        chk("rst_mid_busy", busy0, 0);
        rst = 1'b0;
        ready0 = 1'b1;
        drive(0, 1'b1, 3 * BT);
        q0.push_back(8'h99);
        send(0, 8'h99, BT, -1, 1'b1);
        drive(0, 1'b1, 2 * BT);
        chk("post_rst_rx", q0.size(), 0);
        chk("post_rst_ferr", fe0, 1);
        chk("post_rst_perr", pe0, 0);
        chk("post_rst_ovr", ov0, 1);
        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end
endmodule
